// File: rtl/event_header_reader.sv
// Streams completed event headers (HDR_WORDS x 16-bit) from the header RAM to readout, then releases the buffer.
// Latency: done strobe -> RAM read 2 cycles, first word valid 4 cycles; 3 cycles per word with ready held high.
// Backpressure: valid/ready; a presented word is held stable until accepted, and no further RAM reads are issued until then.
//
// Ports:
//   clk33_i, rst_n_i                 clock, async active-low reset
//   event_done_i, event_buffer_i     completion strobe + buffer id (queued, 4 deep)
//   hdr_addr_o, hdr_rd_o, hdr_dat_i  RAM read port, 1-cycle read latency
//   dout_o/_valid_o/_ready_i/_last_o output word stream; dout_buffer_o = buffer being streamed
//   buffer_release_o, _id_o          one-cycle release strobe after the final word
//   pending_o, overflow_o            queued (not yet started) events; sticky queue overflow
//
// Build option: define HEADER_CHECKSUM_EN to append a 16-bit XOR checksum word
// (carrying dout_last_o) after the header words.
module event_header_reader #(
    parameter int HDR_WORDS = 22
) (
    input  logic        clk33_i,
    input  logic        rst_n_i,
    input  logic        event_done_i,
    input  logic [1:0]  event_buffer_i,
    output logic [7:0]  hdr_addr_o,
    output logic        hdr_rd_o,
    input  logic [15:0] hdr_dat_i,
    output logic [15:0] dout_o,
    output logic        dout_valid_o,
    input  logic        dout_ready_i,
    output logic        dout_last_o,
    output logic [1:0]  dout_buffer_o,
    output logic        buffer_release_o,
    output logic [1:0]  buffer_release_id_o,
    output logic [2:0]  pending_o,
    output logic        overflow_o
);

    localparam logic [5:0] LAST_WORD = 6'(HDR_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_CKSUM,
        S_RELEASE
    } state_t;

    // Buffer-id queue
    logic [1:0]  q_mem_q [4];
    logic [1:0]  q_mem_d [4];
    logic [1:0]  q_rd_ptr_q, q_rd_ptr_d;
    logic [1:0]  q_wr_ptr_q, q_wr_ptr_d;
    logic [2:0]  q_cnt_q, q_cnt_d;
    logic        overflow_q, overflow_d;
    logic        pop, full, push_ok;

    // Sequencer
    state_t      state_q, state_d;
    logic [5:0]  word_q, word_d;
    logic [1:0]  cur_buf_q, cur_buf_d;
    logic [15:0] dout_q, dout_d;
`ifdef HEADER_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
`endif

    // Registered output strobes, derived from the next state so they align with it
    logic        hdr_rd_q, hdr_rd_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        release_q, release_d;
    logic [1:0]  release_id_q, release_id_d;

    always_comb begin
        // The queue pops exactly when the sequencer leaves IDLE. A push that
        // coincides with that pop is always taken, even from a full queue.
        pop      = (state_q == S_IDLE) && (q_cnt_q != 3'd0);
        full     = (q_cnt_q == 3'd4);
        push_ok  = event_done_i && (!full || pop);

        q_mem_d    = q_mem_q;
        q_wr_ptr_d = q_wr_ptr_q;
        q_rd_ptr_d = q_rd_ptr_q;
        if (push_ok) begin
            // On a full push+pop the write slot equals the read slot; the pop
            // below reads the old contents from q_mem_q, so no hazard.
            q_mem_d[q_wr_ptr_q] = event_buffer_i;
            q_wr_ptr_d          = q_wr_ptr_q + 2'd1;
        end
        if (pop) begin
            q_rd_ptr_d = q_rd_ptr_q + 2'd1;
        end
        q_cnt_d    = q_cnt_q + {2'b00, push_ok} - {2'b00, pop};
        overflow_d = overflow_q | (event_done_i & full & ~pop);

        state_d   = state_q;
        word_d    = word_q;
        cur_buf_d = cur_buf_q;
        dout_d    = dout_q;
`ifdef HEADER_CHECKSUM_EN
        acc_d     = acc_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cur_buf_d = q_mem_q[q_rd_ptr_q];
                    word_d    = 6'd0;
`ifdef HEADER_CHECKSUM_EN
                    acc_d     = 16'h0000;
`endif
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                dout_d  = hdr_dat_i;
`ifdef HEADER_CHECKSUM_EN
                acc_d   = acc_q ^ hdr_dat_i;
`endif
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (dout_ready_i) begin
                    if (word_q == LAST_WORD) begin
`ifdef HEADER_CHECKSUM_EN
                        dout_d  = acc_q;
                        state_d = S_CKSUM;
`else
                        state_d = S_RELEASE;
`endif
                    end else begin
                        word_d  = word_q + 6'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_CKSUM: begin
                if (dout_ready_i) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        hdr_rd_d     = (state_d == S_FETCH);
        valid_d      = (state_d == S_PRESENT) || (state_d == S_CKSUM);
`ifdef HEADER_CHECKSUM_EN
        last_d       = (state_d == S_CKSUM);
`else
        last_d       = (state_d == S_PRESENT) && (word_d == LAST_WORD);
`endif
        release_d    = (state_d == S_RELEASE);
        release_id_d = (state_d == S_RELEASE) ? cur_buf_d : 2'd0;
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 4; i++) begin
                q_mem_q[i] <= 2'd0;
            end
            q_rd_ptr_q   <= 2'd0;
            q_wr_ptr_q   <= 2'd0;
            q_cnt_q      <= 3'd0;
            overflow_q   <= 1'b0;
            state_q      <= S_IDLE;
            word_q       <= 6'd0;
            cur_buf_q    <= 2'd0;
            dout_q       <= 16'h0000;
`ifdef HEADER_CHECKSUM_EN
            acc_q        <= 16'h0000;
`endif
            hdr_rd_q     <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            release_q    <= 1'b0;
            release_id_q <= 2'd0;
        end else begin
            q_mem_q      <= q_mem_d;
            q_rd_ptr_q   <= q_rd_ptr_d;
            q_wr_ptr_q   <= q_wr_ptr_d;
            q_cnt_q      <= q_cnt_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            word_q       <= word_d;
            cur_buf_q    <= cur_buf_d;
            dout_q       <= dout_d;
`ifdef HEADER_CHECKSUM_EN
            acc_q        <= acc_d;
`endif
            hdr_rd_q     <= hdr_rd_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            release_q    <= release_d;
            release_id_q <= release_id_d;
        end
    end

    assign hdr_addr_o          = {cur_buf_q, word_q};
    assign hdr_rd_o            = hdr_rd_q;
    assign dout_o              = dout_q;
    assign dout_valid_o        = valid_q;
    assign dout_last_o         = last_q;
    assign dout_buffer_o       = cur_buf_q;
    assign buffer_release_o    = release_q;
    assign buffer_release_id_o = release_id_q;
    assign pending_o           = q_cnt_q;
    assign overflow_o          = overflow_q;

endmodule
